axil_ram_responder: RTL and testbench

- AXI-lite-style responder (subordinate) memory: terminates the read-address (sRA), write-address (sWA) and write-data (sW) streams, and sources the read-data (sR) and write-response (sB) streams.
- It is the counterpart that a map/write initiator block such as a tests_axil_* module drives.
- Holds DEPTH words of INT_N bits in a synchronous RAM.
- Write channel and read channel are independent, each fully pipelined (one transfer per cycle sustained).

---
 rtl/axil_ram_responder_if.sv | 40 ++++
 rtl/axil_ram_responder.sv | 101 ++++++++++
 tb/tb_axil_ram_responder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ram_responder_if.sv
// rtl/axil_ram_responder_if.sv - AXI-lite responder bus bundle; AXIL_RESP_EN adds the sR_resp/sB_resp fields.
interface axil_ram_responder_if #(
    parameter int INT_N  = 32,
    parameter int ADDR_N = 10
);
    logic [ADDR_N-1:0] sRA;
    logic              sRA_valid;
    logic              sRA_ready;
    logic [ADDR_N-1:0] sWA;
    logic              sWA_valid;
    logic              sWA_ready;
    logic [INT_N-1:0]  sW;
    logic              sW_valid;
    logic              sW_ready;
    logic [INT_N-1:0]  sR;
    logic              sR_valid;
    logic              sR_ready;
    logic              sB_valid;
    logic              sB_ready;
`ifdef AXIL_RESP_EN
    logic [1:0]        sR_resp;
    logic [1:0]        sB_resp;
`endif

    modport master (
        output sRA, sRA_valid, sWA, sWA_valid, sW, sW_valid, sR_ready, sB_ready,
        input  sRA_ready, sWA_ready, sW_ready, sR, sR_valid, sB_valid
`ifdef AXIL_RESP_EN
        , input sR_resp, sB_resp
`endif
    );

    modport slave (
        input  sRA, sRA_valid, sWA, sWA_valid, sW, sW_valid, sR_ready, sB_ready,
        output sRA_ready, sWA_ready, sW_ready, sR, sR_valid, sB_valid
`ifdef AXIL_RESP_EN
        , output sR_resp, sB_resp
`endif
    );
endinterface

// File: rtl/axil_ram_responder.sv
// rtl/axil_ram_responder.sv - AXI-lite responder RAM with independent pipelined read/write channels.
// Optional AXIL_RESP_EN adds OKAY/SLVERR responses on sR and sB.
module axil_ram_responder #(
    parameter int INT_N  = 32,
    parameter int ADDR_N = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    axil_ram_responder_if.slave bus
);
    localparam logic [ADDR_N:0] DEPTH_L = (ADDR_N+1)'(DEPTH);

    logic [INT_N-1:0] mem [DEPTH];

    logic             wr_ok;
    logic             wr_fire;
    logic             rd_ok;
    logic             rd_fire;
    logic             wa_in;
    logic             ra_in;
    logic             bypass;
    logic [INT_N-1:0] r_data;
    logic             r_valid;
    logic             b_valid;

    always_comb begin
        wr_ok   = !b_valid || bus.sB_ready;
        wr_fire = !rst && wr_ok && bus.sWA_valid && bus.sW_valid;
        rd_ok   = !r_valid || bus.sR_ready;
        rd_fire = !rst && rd_ok && bus.sRA_valid;
        wa_in   = {1'b0, bus.sWA} < DEPTH_L;
        ra_in   = {1'b0, bus.sRA} < DEPTH_L;
        // Same-cycle write to the address being read wins over the stale RAM word.
        bypass  = wr_fire && wa_in && (bus.sWA == bus.sRA);
    end

    // Address and data are accepted only together.
    assign bus.sWA_ready = wr_fire;
    assign bus.sW_ready  = wr_fire;
    assign bus.sRA_ready = !rst && rd_ok;
    assign bus.sR        = r_data;
    assign bus.sR_valid  = r_valid;
    assign bus.sB_valid  = b_valid;

    always_ff @(posedge clk) begin
        if (wr_fire && wa_in) begin
            mem[bus.sWA] <= bus.sW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            b_valid <= 1'b0;
        end else begin
            if (rd_fire) begin
                r_valid <= 1'b1;
                if (!ra_in) begin
                    r_data <= '0;
                end else if (bypass) begin
                    r_data <= bus.sW;
                end else begin
                    r_data <= mem[bus.sRA];
                end
            end else if (bus.sR_ready) begin
                r_valid <= 1'b0;
            end

            if (wr_fire) begin
                b_valid <= 1'b1;
            end else if (bus.sB_ready) begin
                b_valid <= 1'b0;
            end
        end
    end

`ifdef AXIL_RESP_EN
    logic [1:0] r_resp;
    logic [1:0] b_resp;

    assign bus.sR_resp = r_resp;
    assign bus.sB_resp = b_resp;

    // Responses only change on a fire, so they stay stable with their beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp <= 2'b00;
            b_resp <= 2'b00;
        end else begin
            if (rd_fire) begin
                r_resp <= ra_in ? 2'b00 : 2'b10;
            end
            if (wr_fire) begin
                b_resp <= wa_in ? 2'b00 : 2'b10;
            end
        end
    end
`endif
endmodule

// File: tb/tb_axil_ram_responder.sv
// tb/tb_axil_ram_responder.sv - self-checking bench for axil_ram_responder (DEPTH=1000, AXIL_RESP_EN aware).
module tb_axil_ram_responder;
    localparam int INT_N  = 32;
    localparam int ADDR_N = 10;
    localparam int DEPTH  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_ram_responder_if #(.INT_N(INT_N), .ADDR_N(ADDR_N)) bus ();

    axil_ram_responder #(.INT_N(INT_N), .ADDR_N(ADDR_N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] resp_of(input logic [ADDR_N-1:0] a);
        return (int'(a) >= DEPTH) ? 2'b10 : 2'b00;
    endfunction

    // Reference model: a plain word array plus in-order queues of outstanding beats.
    typedef struct {
        logic [INT_N-1:0] data;
        logic [1:0]       resp;
    } rbeat_t;

    logic [INT_N-1:0] ref_mem [DEPTH];
    rbeat_t           r_q[$];
    logic [1:0]       b_q[$];
    rbeat_t           mon_e;
    logic [1:0]       mon_b;
    int               r_cnt = 0;
    int               b_cnt = 0;
    bit               hold_r = 0;
    bit               hold_b = 0;
    logic [INT_N-1:0] held_r;

    always @(negedge clk) begin
        if (rst) begin
            r_q.delete();
            b_q.delete();
            hold_r = 0;
            hold_b = 0;
        end else begin
            if (hold_r) begin
                chk("sR_valid held while stalled", bus.sR_valid, 1);
                chk("sR stable while stalled", bus.sR, held_r);
            end
            if (hold_b) chk("sB_valid held while stalled", bus.sB_valid, 1);
            chk("sRA_ready rule", bus.sRA_ready, !bus.sR_valid || bus.sR_ready);
            chk("sWA_ready join", bus.sWA_ready,
                (!bus.sB_valid || bus.sB_ready) && bus.sWA_valid && bus.sW_valid);
            chk("sW_ready join", bus.sW_ready,
                (!bus.sB_valid || bus.sB_ready) && bus.sWA_valid && bus.sW_valid);

            if (bus.sR_valid && bus.sR_ready) begin
                r_cnt++;
                if (r_q.size() == 0) begin
                    chk("sR beat without read", 1, 0);
                end else begin
                    mon_e = r_q.pop_front();
                    chk("sR data in order", bus.sR, mon_e.data);
`ifdef AXIL_RESP_EN
                    chk("sR_resp", bus.sR_resp, mon_e.resp);
`endif
                end
            end
            if (bus.sB_valid && bus.sB_ready) begin
                b_cnt++;
                if (b_q.size() == 0) begin
                    chk("sB beat without write", 1, 0);
                end else begin
                    mon_b = b_q.pop_front();
`ifdef AXIL_RESP_EN
                    chk("sB_resp", bus.sB_resp, mon_b);
`endif
                end
            end
            // Apply the write before computing the read: write-first on collision.
            if (bus.sWA_valid && bus.sW_valid && bus.sWA_ready) begin
                if (int'(bus.sWA) < DEPTH) ref_mem[bus.sWA] = bus.sW;
                b_q.push_back(resp_of(bus.sWA));
            end
            if (bus.sRA_valid && bus.sRA_ready) begin
                mon_e.data = (int'(bus.sRA) < DEPTH) ? ref_mem[bus.sRA] : '0;
                mon_e.resp = resp_of(bus.sRA);
                r_q.push_back(mon_e);
            end
            hold_r = bus.sR_valid && !bus.sR_ready;
            held_r = bus.sR;
            hold_b = bus.sB_valid && !bus.sB_ready;
        end
    end

    typedef struct {
        bit                we;
        logic [ADDR_N-1:0] wa;
        logic [INT_N-1:0]  wd;
        bit                re;
        logic [ADDR_N-1:0] ra;
        logic [INT_N-1:0]  exp_r;
    } vec_t;

    vec_t tbl[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sRA_valid = 0;
        bus.sWA_valid = 0;
        bus.sW_valid  = 0;
    endtask

    task automatic run_random(input int seed, input int cycles);
        bit w_pend;
        bit r_pend;
        int s;
        s = $urandom(seed);
        w_pend = 0;
        r_pend = 0;
        for (int c = 0; c < cycles; c++) begin
            if (!w_pend && $urandom_range(0, 3) != 0) begin
                w_pend = 1;
                bus.sWA = ADDR_N'($urandom_range(0, 1023));
                bus.sW  = $urandom;
            end
            if (!r_pend && $urandom_range(0, 3) != 0) begin
                r_pend = 1;
                bus.sRA = ADDR_N'($urandom_range(0, 1023));
            end
            bus.sWA_valid = w_pend && ($urandom_range(0, 3) != 0);
            bus.sW_valid  = w_pend && ($urandom_range(0, 3) != 0);
            bus.sRA_valid = r_pend && ($urandom_range(0, 3) != 0);
            bus.sR_ready  = $urandom_range(0, 3) != 0;
            bus.sB_ready  = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (bus.sWA_valid && bus.sW_valid && bus.sWA_ready) w_pend = 0;
            if (bus.sRA_valid && bus.sRA_ready) r_pend = 0;
            step();
        end
        idle_inputs();
        bus.sR_ready = 1;
        bus.sB_ready = 1;
        repeat (4) step();
        @(negedge clk);
        chk("random: no lost sR beats", r_q.size(), 0);
        chk("random: no lost sB beats", b_q.size(), 0);
        step();
    endtask

    int b_base;
    int r_base;
    int stalls;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 10'd5,    32'h7,    0, 10'd0,    32'h0};
        tbl[1] = '{1, 10'd5,    32'h9,    1, 10'd5,    32'h9};
        tbl[2] = '{0, 10'd0,    32'h0,    1, 10'd5,    32'h9};
        tbl[3] = '{1, 10'd1000, 32'hAA,   1, 10'd1000, 32'h0};
        tbl[4] = '{0, 10'd0,    32'h0,    1, 10'd0,    32'h3};
        tbl[5] = '{0, 10'd0,    32'h0,    1, 10'd1000, 32'h0};
        tbl[6] = '{1, 10'd999,  32'h1234, 1, 10'd999,  32'h1234};
        tbl[7] = '{1, 10'd0,    32'h55,   1, 10'd999,  32'h1234};
        tbl[8] = '{0, 10'd0,    32'h0,    1, 10'd0,    32'h55};
        tbl[9] = '{1, 10'd1023, 32'hBEEF, 1, 10'd1023, 32'h0};

        // Reset with every valid high.
        bus.sRA = '0; bus.sWA = '0; bus.sW = '0;
        bus.sRA_valid = 1; bus.sWA_valid = 1; bus.sW_valid = 1;
        bus.sR_ready = 1; bus.sB_ready = 1;
        rst = 1;
        repeat (2) begin
            @(negedge clk);
            chk("reset sR_valid", bus.sR_valid, 0);
            chk("reset sB_valid", bus.sB_valid, 0);
            chk("reset sR", bus.sR, 0);
        end
        step();
        rst = 0;
        bus.sRA_valid = 0;
        bus.sWA = 10'd3;
        bus.sW  = 32'h33;
        @(negedge clk);
        chk("first write sB_valid before fire", bus.sB_valid, 0);
        chk("first write ready", bus.sWA_ready, 1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("sB_valid one cycle after first fire", bus.sB_valid, 1);
        step();

        // Join: address alone must not be consumed.
        b_base = b_cnt;
        bus.sWA = 10'd7; bus.sW = 32'h77; bus.sWA_valid = 1; bus.sW_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("join sWA_ready while sW idle", bus.sWA_ready, 0);
            chk("join sW_ready while sW idle", bus.sW_ready, 0);
            step();
        end
        bus.sW_valid = 1;
        @(negedge clk);
        chk("join fires on cycle 5", bus.sWA_ready, 1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("join sB after fire", bus.sB_valid, 1);
        step();
        @(negedge clk);
        chk("join single write", b_cnt - b_base, 1);
        chk("join no second sB", bus.sB_valid, 0);
        step();

        // Back-to-back fill with overlapped readback of the previous address.
        b_base = b_cnt;
        r_base = r_cnt;
        stalls = 0;
        for (int i = 0; i <= 1024; i++) begin
            bus.sWA_valid = (i < 1024);
            bus.sW_valid  = (i < 1024);
            bus.sWA       = ADDR_N'(i);
            bus.sW        = INT_N'(i + 3);
            bus.sRA_valid = (i > 0);
            bus.sRA       = ADDR_N'(i - 1);
            @(negedge clk);
            if ((i < 1024 && !bus.sWA_ready) || (i > 0 && !bus.sRA_ready)) stalls++;
            step();
        end
        idle_inputs();
        repeat (3) step();
        @(negedge clk);
        chk("fill sB beat count", b_cnt - b_base, 1024);
        chk("fill sR beat count", r_cnt - r_base, 1024);
        chk("fill full throughput", stalls, 0);
        step();

        // Directed vectors: collision, out-of-range, bypass edge cases.
        for (int k = 0; k < 10; k++) begin
            bus.sWA_valid = tbl[k].we;
            bus.sW_valid  = tbl[k].we;
            bus.sWA       = tbl[k].wa;
            bus.sW        = tbl[k].wd;
            bus.sRA_valid = tbl[k].re;
            bus.sRA       = tbl[k].ra;
            @(negedge clk);
            chk($sformatf("tbl[%0d] sWA_ready", k), bus.sWA_ready, tbl[k].we);
            step();
            idle_inputs();
            @(negedge clk);
            chk($sformatf("tbl[%0d] sR_valid", k), bus.sR_valid, tbl[k].re);
            chk($sformatf("tbl[%0d] sB_valid", k), bus.sB_valid, tbl[k].we);
            if (tbl[k].re) chk($sformatf("tbl[%0d] sR", k), bus.sR, tbl[k].exp_r);
`ifdef AXIL_RESP_EN
            if (tbl[k].re) chk($sformatf("tbl[%0d] sR_resp", k), bus.sR_resp, resp_of(tbl[k].ra));
            if (tbl[k].we) chk($sformatf("tbl[%0d] sB_resp", k), bus.sB_resp, resp_of(tbl[k].wa));
`endif
            step();
        end

        run_random(21, 600);
        run_random(42, 600);

        // Reset while a read beat and a write response are both pending.
        bus.sR_ready = 0; bus.sB_ready = 0;
        bus.sRA = 10'd10; bus.sRA_valid = 1;
        bus.sWA = 10'd11; bus.sW = 32'hC0DE; bus.sWA_valid = 1; bus.sW_valid = 1;
        step();
        idle_inputs();
        @(negedge clk);
        chk("pre-reset sR pending", bus.sR_valid, 1);
        chk("pre-reset sB pending", bus.sB_valid, 1);
        step();
        rst = 1;
        step();
        @(negedge clk);
        chk("mid reset drops sR", bus.sR_valid, 0);
        chk("mid reset drops sB", bus.sB_valid, 0);
        chk("mid reset clears sR", bus.sR, 0);
        step();
        rst = 0;
        bus.sR_ready = 1; bus.sB_ready = 1;
        repeat (2) step();
        @(negedge clk);
        chk("post reset idle sR_valid", bus.sR_valid, 0);
        chk("post reset idle sB_valid", bus.sB_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
